s_axis_cc_arb: RTL and testbench

Packet-granular round-robin arbiter that shares the single completer-completion (CC) AXI-Stream path into the PCIe core between NUM_PORTS completion sources (e.g. CSR/BAR completer, DMA status completer). It sits upstream of the CC header adapter and presents one CC stream to it. A grant is held from the first beat to tlast, so TLPs are never interleaved. A registered skid stage on the output breaks the tready timing path.

---
 rtl/pcie_cc_pkg.sv | 10 +
 rtl/axis_skid_reg.sv | 64 ++++++
 rtl/s_axis_cc_arb.sv | 113 +++++++++++
 tb/tb_s_axis_cc_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_cc_pkg.sv
// Definitions shared by the PCIe completer-completion (CC) stream blocks.
package pcie_cc_pkg;

    localparam int unsigned CC_TUSER_W    = 4;
    localparam int unsigned CC_TUSER_ECRC = 0;
    localparam int unsigned CC_TUSER_DISC = 3;

    typedef enum logic {IDLE, PASS} cc_arb_state_e;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered skid buffer; input ready depends only on occupancy, never on out_ready_i.
module axis_skid_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic             ready_q, ready_d, valid_q, valid_d;
    logic             push, pop;

    always_comb begin
        push    = in_valid_i & ready_q;
        pop     = valid_q & out_ready_i;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data_i;
                else                 tail_d = in_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // Push with pop only happens at count 1 (ready is low when full).
            2'b11:   head_d = in_data_i;
            default: ;
        endcase
        ready_d = (count_d != 2'd2);
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = head_q;

endmodule

// File: rtl/s_axis_cc_arb.sv
// Packet-granular round-robin arbiter merging several CC AXI-Stream sources into one,
// holding each grant until tlast and feeding a two-entry skid on the output.
module s_axis_cc_arb
    import pcie_cc_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             user_clk,
    input  logic                             user_reset_n,
    input  logic [NUM_PORTS-1:0]             s_tvalid,
    output logic [NUM_PORTS-1:0]             s_tready,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_tkeep,
    input  logic [NUM_PORTS*CC_TUSER_W-1:0]  s_tuser,
    output logic                             m_tvalid,
    input  logic [3:0]                       m_tready,
    output logic                             m_tlast,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [KEEP_WIDTH-1:0]            m_tkeep,
    output logic [CC_TUSER_W-1:0]            m_tuser,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_id,
    output logic                             busy
);

    localparam int unsigned IdW   = $clog2(NUM_PORTS);
    localparam int unsigned SkidW = CC_TUSER_W + KEEP_WIDTH + 1 + DATA_WIDTH;

    cc_arb_state_e           state_q;
    logic [IdW-1:0]          rr_q, grant_q, pick;
    logic                    found;
    logic                    sel_valid, sel_last, in_valid, in_hs;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;
    logic [CC_TUSER_W-1:0]   sel_user;
    logic                    skid_ready, skid_valid;
    logic [SkidW-1:0]        skid_out;
    logic                    unused_m_tready;

    // First requesting port at or after rr_q, wrapping modulo NUM_PORTS.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = (32'(rr_q) + i) % NUM_PORTS;
            if (!found && s_tvalid[idx]) begin
                found = 1'b1;
                pick  = IdW'(idx);
            end
        end
    end

    always_comb begin
        sel_valid = s_tvalid[grant_q];
        sel_last  = s_tlast[grant_q];
        sel_data  = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user  = s_tuser[grant_q*CC_TUSER_W +: CC_TUSER_W];
        in_valid  = (state_q == PASS) & sel_valid;
        in_hs     = in_valid & skid_ready;
        s_tready  = '0;
        if (state_q == PASS) s_tready[grant_q] = skid_ready;
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q <= pick;
                        state_q <= PASS;
                    end
                end
                PASS: begin
                    if (in_hs && sel_last) begin
                        rr_q    <= (32'(grant_q) == NUM_PORTS - 1) ? '0 : grant_q + 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_skid_reg #(
        .WIDTH (SkidW)
    ) u_skid (
        .clk_i       (user_clk),
        .rst_ni      (user_reset_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (skid_ready),
        .in_data_i   ({sel_user, sel_keep, sel_last, sel_data}),
        .out_valid_o (skid_valid),
        .out_ready_i (m_tready[0]),
        .out_data_o  (skid_out)
    );

    assign {m_tuser, m_tkeep, m_tlast, m_tdata} = skid_out;
    assign m_tvalid        = skid_valid;
    assign grant_id        = grant_q;
    // A full skid outside PASS can only be holding the penultimate and final beats.
    assign busy            = (state_q == PASS) | ~skid_ready;
    assign unused_m_tready = ^m_tready[3:1];

endmodule

// File: tb/tb_s_axis_cc_arb.sv
// Bench for s_axis_cc_arb: directed scenarios plus randomized traffic against a
// queue-based round-robin packet model.
module tb_s_axis_cc_arb;

    localparam int NP = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [3:0]  user;
        logic [3:0]  keep;
        logic        last;
        logic [31:0] data;
    } beat_t;

    logic             user_clk = 1'b0;
    logic             user_reset_n;
    logic [NP-1:0]    s_tvalid, s_tready, s_tlast;
    logic [NP*DW-1:0] s_tdata;
    logic [NP*4-1:0]  s_tkeep, s_tuser;
    logic             m_tvalid, m_tlast, busy;
    logic [3:0]       m_tready, m_tkeep, m_tuser;
    logic [31:0]      m_tdata;
    logic [1:0]       grant_id;

    s_axis_cc_arb #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (DW / 8)
    ) dut (
        .user_clk     (user_clk),
        .user_reset_n (user_reset_n),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .s_tuser      (s_tuser),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .m_tdata      (m_tdata),
        .m_tkeep      (m_tkeep),
        .m_tuser      (m_tuser),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 user_clk = ~user_clk;

    int    n_checks = 0, n_pass = 0;
    int    cyc = 0, first_mv = -1, since_last = 100, rr_m = 0, seq = 0;
    bit    gap_chk = 0, gap_en = 0, rnd_ready = 0, prev_stall = 0;
    beat_t prev_beat;
    bit    sop[NP];
    int    beats_in[NP], pause_at[NP], pause_left[NP];
    bit    ready_script[$];
    beat_t src_q[NP][$];
    beat_t tmp_q[NP][$];
    beat_t exp_q[$];
    int    exp_grant[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic beat_t m_obs();
        return beat_t'({m_tuser, m_tkeep, m_tlast, m_tdata});
    endfunction

    task automatic add_pkt(input int p, input int len, input logic [31:0] d0, input bit rnd);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = rnd ? {8'(p), 8'(seq), 16'($urandom)} : d0 + 32'(k);
            b.keep = 4'($urandom);
            b.user = 4'($urandom);
            b.last = (k == len - 1);
            src_q[p].push_back(b);
        end
        seq++;
    endtask

    // Round-robin over ports that have packets pending, whole packets at a time.
    task automatic plan();
        int    pick;
        beat_t b;
        for (int i = 0; i < NP; i++) tmp_q[i] = src_q[i];
        forever begin
            pick = -1;
            for (int k = 0; k < NP; k++)
                if (pick < 0 && tmp_q[(rr_m + k) % NP].size() > 0) pick = (rr_m + k) % NP;
            if (pick < 0) break;
            exp_grant.push_back(pick);
            do begin
                b = tmp_q[pick].pop_front();
                exp_q.push_back(b);
            end while (!b.last);
            rr_m = (pick + 1) % NP;
        end
    endtask

    task automatic step();
        beat_t      b;
        int         eg;
        bit         r;
        logic [3:0] msk;
        @(negedge user_clk);
        cyc++;
        since_last++;
        if (m_tvalid && first_mv < 0) first_mv = cyc;
        if (prev_stall) begin
            check("hold_valid", 64'(m_tvalid), 64'(1));
            check("hold_data", 64'(m_obs()), 64'(prev_beat));
        end
        check("ready_onehot", 64'($countones(s_tready) <= 1), 64'(1));
        if (gap_chk && since_last == 1) check("gap_idle", 64'(m_tvalid), 64'(0));
        if (gap_chk && since_last == 2 && exp_q.size() > 0)
            check("gap_one", 64'(m_tvalid), 64'(1));
        for (int i = 0; i < NP; i++) begin
            s_tvalid[i] = 1'b0;
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                s_tdata[i*DW +: DW] = b.data;
                s_tkeep[i*4 +: 4]   = b.keep;
                s_tuser[i*4 +: 4]   = b.user;
                s_tlast[i]          = b.last;
                if (!sop[i] && beats_in[i] == pause_at[i] && pause_left[i] > 0) begin
                    pause_left[i]--;
                    msk = 4'b0001 << i;
                    check("pause_grant", 64'(grant_id), 64'(i));
                    check("pause_others", 64'(s_tready & ~msk), 64'(0));
                end else begin
                    s_tvalid[i] = sop[i] || !gap_en || ($urandom_range(0, 3) != 0);
                end
            end
        end
        r = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (ready_script.size() > 0) r = ready_script.pop_front();
        m_tready = {3'($urandom), r};
        for (int i = 0; i < NP; i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
                if (sop[i]) begin
                    eg = -1;
                    if (exp_grant.size() > 0) eg = exp_grant.pop_front();
                    check("grant_order", 64'(i), 64'(eg));
                    check("grant_id", 64'(grant_id), 64'(i));
                    beats_in[i] = 0;
                end
                b = src_q[i].pop_front();
                beats_in[i]++;
                sop[i] = b.last;
            end
        end
        if (m_tvalid && m_tready[0]) begin
            check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                check("m_beat", 64'(m_obs()), 64'(b));
                if (b.last) since_last = 0;
            end
        end
        prev_stall = m_tvalid && !m_tready[0];
        prev_beat  = m_obs();
    endtask

    task automatic run_until_done(input int budget);
        int n;
        bit pending;
        n = 0;
        forever begin
            pending = exp_q.size() > 0;
            for (int i = 0; i < NP; i++) if (src_q[i].size() > 0) pending = 1;
            if (!pending || n >= budget) break;
            step();
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic flush_model();
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            sop[i] = 1'b1;
            beats_in[i] = 0;
            pause_left[i] = 0;
        end
        exp_q.delete();
        exp_grant.delete();
        ready_script.delete();
        s_tvalid   = '0;
        rr_m       = 0;
        prev_stall = 0;
        since_last = 100;
    endtask

    initial begin
        user_reset_n = 1'b0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        m_tready = 4'hF;
        for (int i = 0; i < NP; i++) pause_at[i] = -1;
        flush_model();
        repeat (2) @(negedge user_clk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_s_tready", 64'(s_tready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        user_reset_n = 1'b1;

        // Single 3-beat TLP on port 0, sink always ready.
        first_mv = -1;
        add_pkt(0, 3, 32'hA0, 0);
        plan();
        step();
        check("t1_latency", 64'(first_mv), 64'(-1));
        first_mv = -1;
        check("t1_first_ready", 64'(s_tready), 64'(0));
        begin
            int t0;
            t0 = cyc;
            run_until_done(50);
            check("t1_latency", 64'(first_mv - t0), 64'(2));
        end
        check("t1_busy_after", 64'(busy), 64'(0));

        // Port 1 pauses mid-packet while port 0 waits; rr pointer now at 1.
        add_pkt(1, 4, 32'h100, 0);
        add_pkt(0, 2, 32'h200, 0);
        pause_at[1] = 1;
        pause_left[1] = 5;
        plan();
        run_until_done(100);
        check("t4_pause_used", 64'(pause_left[1]), 64'(0));
        pause_at[1] = -1;

        // Ports 0 and 1 continuously valid with 2-beat TLPs: alternate, one idle gap.
        for (int k = 0; k < 3; k++) begin
            add_pkt(0, 2, 0, 1);
            add_pkt(1, 2, 0, 1);
        end
        plan();
        gap_chk = 1;
        since_last = 100;
        run_until_done(200);
        gap_chk = 0;

        // Sink stalls mid-TLP: ready 1,0,0,1 once the first beat is out.
        add_pkt(0, 4, 32'h300, 0);
        plan();
        ready_script = '{1, 1, 1, 0, 0, 1};
        step();
        step();
        check("t3_ready_k1", 64'(s_tready), 64'(4'b0001));
        step();
        step();
        check("t3_ready_k3", 64'(s_tready[0]), 64'(1));
        step();
        check("t3_ready_full", 64'(s_tready[0]), 64'(0));
        check("t3_busy", 64'(busy), 64'(1));
        step();
        check("t3_ready_full2", 64'(s_tready[0]), 64'(0));
        run_until_done(100);

        // Randomized traffic: random lengths, source bubbles and sink backpressure.
        gap_en = 1;
        rnd_ready = 1;
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < NP; p++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) add_pkt(p, $urandom_range(1, 4), 0, 1);
            end
            add_pkt(r % NP, 1, 0, 1);
            plan();
            run_until_done(3000);
        end
        gap_en = 0;
        rnd_ready = 0;

        // Port 3 alone, then ports 0 and 3: pointer wraps so port 0 goes next.
        add_pkt(3, 2, 32'h400, 0);
        plan();
        run_until_done(50);
        add_pkt(0, 2, 32'h500, 0);
        add_pkt(3, 1, 32'h600, 0);
        plan();
        run_until_done(50);

        // Single-beat TLP on port 0 moves rr to 1, then reset lands mid-packet on port 2.
        add_pkt(0, 1, 32'h700, 0);
        plan();
        run_until_done(50);
        add_pkt(2, 4, 32'h800, 0);
        plan();
        step();
        step();
        step();
        check("t5_pre_busy", 64'(busy), 64'(1));
        #2;
        user_reset_n = 1'b0;
        #1;
        check("t5_m_tvalid", 64'(m_tvalid), 64'(0));
        check("t5_s_tready", 64'(s_tready), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_grant_id", 64'(grant_id), 64'(0));
        flush_model();
        @(negedge user_clk);
        user_reset_n = 1'b1;
        add_pkt(1, 2, 32'h900, 0);
        add_pkt(0, 2, 32'hA00, 0);
        plan();
        run_until_done(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
